matrix_op_controller: RTL and testbench

Sequencer that drives the matrix ALU as its initiator. It accepts one command (opcode, operand/result row addresses, scalar) and loads matrix A, and B where needed, row by row from a 40-bit matrix memory. It then presents the operands and opcode to the ALU, captures `C_flat` and the overflow flag, and writes the result back to memory. It sits between the host command interface and the ALU/memory pair.

---
 rtl/coprocessor_pkg.sv | 57 +++++
 rtl/matrix_op_controller_if.sv | 50 +++++
 rtl/matrix_op_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_matrix_op_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coprocessor_pkg.sv
// Shared coprocessor definitions: matrix geometry, ALU opcodes, controller state encoding
// and row pack/unpack helpers.
package coprocessor_pkg;

    localparam int unsigned MAT_N  = 5;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned ROW_W  = MAT_N * ELEM_W;
    localparam int unsigned FLAT_W = MAT_N * ROW_W;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ROW_IDX_W = 3;

    typedef logic [OP_W-1:0]      opcode_t;
    typedef logic [ROW_IDX_W-1:0] row_idx_t;

    localparam opcode_t OP_NOP = 3'b000;
    localparam opcode_t OP_ADD = 3'b001;
    localparam opcode_t OP_SUB = 3'b010;
    localparam opcode_t OP_MUL = 3'b011;
    localparam opcode_t OP_TRN = 3'b100;
    localparam opcode_t OP_NEG = 3'b101;
    localparam opcode_t OP_SCL = 3'b110;
    localparam opcode_t OP_DET = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WAIT,
        S_STORE,
        S_FIN
    } mop_state_e;

    function automatic logic op_legal(input opcode_t op);
        return (op != OP_NOP) && (op != OP_DET);
    endfunction

    // Ops that consume a second matrix operand.
    function automatic logic op_binary(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    function automatic logic [ROW_W-1:0] get_row(input logic [FLAT_W-1:0] flat,
                                                 input row_idx_t          idx);
        return flat[ROW_W*32'(idx) +: ROW_W];
    endfunction

    function automatic logic [FLAT_W-1:0] put_row(input logic [FLAT_W-1:0] flat,
                                                  input row_idx_t          idx,
                                                  input logic [ROW_W-1:0]  row);
        logic [FLAT_W-1:0] r;
        r = flat;
        r[ROW_W*32'(idx) +: ROW_W] = row;
        return r;
    endfunction

endpackage

// File: rtl/matrix_op_controller_if.sv
// Bundle of host command, matrix-memory and ALU signals seen by the matrix op controller.
interface matrix_op_controller_if #(
    parameter int unsigned ADDR_W = 8
) ();
    import coprocessor_pkg::*;

    logic                 start;
    logic [OP_W-1:0]      cmd_opcode;
    logic [ADDR_W-1:0]    cmd_addr_a;
    logic [ADDR_W-1:0]    cmd_addr_b;
    logic [ADDR_W-1:0]    cmd_addr_c;
    logic [ELEM_W-1:0]    cmd_scalar;

    logic [ADDR_W-1:0]    mem_addr;
    logic [ROW_W-1:0]     mem_rdata;
    logic [ROW_W-1:0]     mem_wdata;
    logic                 mem_we;

    logic [FLAT_W-1:0]    alu_A_flat;
    logic [FLAT_W-1:0]    alu_B_flat;
    logic [ELEM_W-1:0]    alu_f;
    logic [OP_W-1:0]      alu_opcode;
    logic [FLAT_W-1:0]    alu_C_flat;
    logic                 alu_overflow;
    logic                 alu_done;

    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic                 error;

    // Controller side.
    modport master (
        input  start, cmd_opcode, cmd_addr_a, cmd_addr_b, cmd_addr_c, cmd_scalar,
        input  mem_rdata, alu_C_flat, alu_overflow, alu_done,
        output mem_addr, mem_wdata, mem_we,
        output alu_A_flat, alu_B_flat, alu_f, alu_opcode,
        output busy, done, overflow, error
    );

    // Host, memory and ALU side.
    modport slave (
        output start, cmd_opcode, cmd_addr_a, cmd_addr_b, cmd_addr_c, cmd_scalar,
        output mem_rdata, alu_C_flat, alu_overflow, alu_done,
        input  mem_addr, mem_wdata, mem_we,
        input  alu_A_flat, alu_B_flat, alu_f, alu_opcode,
        input  busy, done, overflow, error
    );

endinterface

// File: rtl/matrix_op_controller.sv
// Command sequencer for the matrix ALU: loads A (and B) row by row from matrix memory,
// runs the ALU, captures the result and writes C back.
module matrix_op_controller
    import coprocessor_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MUL_TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    matrix_op_controller_if.master bus
);

    localparam int unsigned TMR_W    = (MUL_TIMEOUT < 2) ? 1 : $clog2(MUL_TIMEOUT + 1);
    localparam row_idx_t    LAST_ROW = ROW_IDX_W'(MAT_N - 1);
    localparam row_idx_t    LOAD_END = ROW_IDX_W'(MAT_N);

    mop_state_e          state_q, state_d;
    row_idx_t            row_q, row_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    opcode_t             op_q, op_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [ADDR_W-1:0]   addr_c_q, addr_c_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [ROW_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [FLAT_W-1:0]   a_q, a_d;
    logic [FLAT_W-1:0]   b_q, b_d;
    logic [FLAT_W-1:0]   c_q, c_d;
    logic [ELEM_W-1:0]   f_q, f_d;
    opcode_t             alu_op_q, alu_op_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    logic                capture;
    logic [TMR_W-1:0]    tmr_k;
    logic [ADDR_W-1:0]   load_base;
    row_idx_t            load_row;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        tmr_d       = tmr_q;
        op_d        = op_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_c_d    = addr_c_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        f_d         = f_q;
        alu_op_d    = alu_op_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        err_d       = err_q;
        capture     = 1'b0;
        tmr_k       = tmr_q + TMR_W'(1);
        load_base   = (state_q == S_LOAD_A) ? addr_a_q : addr_b_q;
        load_row    = row_q - ROW_IDX_W'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.cmd_opcode;
                    addr_a_d = bus.cmd_addr_a;
                    addr_b_d = bus.cmd_addr_b;
                    addr_c_d = bus.cmd_addr_c;
                    f_d      = bus.cmd_scalar;
                    b_d      = '0;
                    row_d    = '0;
                    tmr_d    = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    if (op_legal(bus.cmd_opcode)) begin
                        state_d    = S_LOAD_A;
                        mem_addr_d = bus.cmd_addr_a;
                    end else begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end
                end
            end

            // row_q counts issued addresses; each row lands one cycle after its address.
            S_LOAD_A, S_LOAD_B: begin
                row_d = row_q + ROW_IDX_W'(1);
                if (row_q < LAST_ROW) begin
                    mem_addr_d = load_base + ADDR_W'(row_q) + ADDR_W'(1);
                end
                if (row_q != '0) begin
                    if (state_q == S_LOAD_A) begin
                        a_d = put_row(a_q, load_row, bus.mem_rdata);
                    end else begin
                        b_d = put_row(b_q, load_row, bus.mem_rdata);
                    end
                end
                if (row_q == LOAD_END) begin
                    row_d = '0;
                    if ((state_q == S_LOAD_A) && op_binary(op_q)) begin
                        state_d    = S_LOAD_B;
                        mem_addr_d = addr_b_q;
                    end else begin
                        state_d  = S_EXEC;
                        alu_op_d = op_q;
                    end
                end
            end

            // tmr_k is the number of edges since the opcode was first presented.
            S_EXEC, S_WAIT: begin
                tmr_d = tmr_k;
                if (op_q == OP_MUL) begin
                    if (bus.alu_done) begin
                        capture = 1'b1;
                    end else if (tmr_k >= TMR_W'(MUL_TIMEOUT)) begin
                        state_d  = S_FIN;
                        err_d    = 1'b1;
                        alu_op_d = OP_NOP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (state_q == S_WAIT) begin
                    capture = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_STORE: begin
                if (row_q == LAST_ROW) begin
                    state_d = S_FIN;
                end else begin
                    row_d       = row_q + ROW_IDX_W'(1);
                    mem_addr_d  = addr_c_q + ADDR_W'(row_q) + ADDR_W'(1);
                    mem_wdata_d = get_row(c_q, row_q + ROW_IDX_W'(1));
                    mem_we_d    = 1'b1;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result capture starts the write-back of row 0 in the same edge.
        if (capture) begin
            c_d         = bus.alu_C_flat;
            ovf_d       = bus.alu_overflow;
            alu_op_d    = OP_NOP;
            state_d     = S_STORE;
            row_d       = '0;
            mem_addr_d  = addr_c_q;
            mem_wdata_d = get_row(bus.alu_C_flat, '0);
            mem_we_d    = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_q       <= '0;
            tmr_q       <= '0;
            op_q        <= OP_NOP;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            f_q         <= '0;
            alu_op_q    <= OP_NOP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            row_q       <= row_d;
            tmr_q       <= tmr_d;
            op_q        <= op_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_c_q    <= addr_c_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            f_q         <= f_d;
            alu_op_q    <= alu_op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.alu_A_flat = a_q;
    assign bus.alu_B_flat = b_q;
    assign bus.alu_f      = f_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.error      = err_q;

endmodule

// File: tb/tb_matrix_op_controller.sv
// Self-checking bench: memory and ALU models around the controller, directed scenarios
// plus randomized commands checked against a signed-arithmetic matrix model.
module tb_matrix_op_controller;
    import coprocessor_pkg::*;

    localparam int unsigned MUL_TO = 255;

    logic clock;
    logic reset_n;

    matrix_op_controller_if #(.ADDR_W(8)) bus ();

    matrix_op_controller #(.ADDR_W(8), .MUL_TIMEOUT(MUL_TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [ROW_W-1:0] mem [0:255];
    int               wr_cnt;
    int               b_reads;
    logic             b_mon;
    logic [7:0]       b_base;
    int               mul_k;
    logic             mul_stall;
    int               op_age;
    int               n_chk;
    int               n_pass;

    // Synchronous-read row memory.
    always @(posedge clock) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    always @(negedge clock) begin
        logic [7:0] diff;
        diff = bus.mem_addr - b_base;
        if (bus.busy && b_mon && diff < 8'd5) b_reads = b_reads + 1;
    end

    function automatic int el(input logic [FLAT_W-1:0] m, input int i, input int j);
        logic [7:0] v;
        v = m[40*i + 8*j +: 8];
        return int'($signed(v));
    endfunction

    // Signed 8-bit element arithmetic; bit FLAT_W is the overflow flag.
    function automatic logic [FLAT_W:0] alu_ref(input logic [2:0] op, input logic [FLAT_W-1:0] ma,
                                                input logic [FLAT_W-1:0] mb, input logic [7:0] f);
        logic [FLAT_W-1:0] mc;
        logic              ov;
        int                v;
        mc = '0;
        ov = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                case (op)
                    OP_ADD: v = el(ma, i, j) + el(mb, i, j);
                    OP_SUB: v = el(ma, i, j) - el(mb, i, j);
                    OP_MUL: begin
                        v = 0;
                        for (int k = 0; k < 5; k++) v = v + el(ma, i, k) * el(mb, k, j);
                    end
                    OP_TRN: v = el(ma, j, i);
                    OP_NEG: v = -el(ma, i, j);
                    OP_SCL: v = el(ma, i, j) * int'($signed(f));
                    default: v = 0;
                endcase
                if (v > 127 || v < -128) ov = 1'b1;
                mc[40*i + 8*j +: 8] = 8'(v);
            end
        end
        return {ov, mc};
    endfunction

    always @(posedge clock) op_age <= (bus.alu_opcode != OP_NOP) ? op_age + 1 : 0;

    // ALU model: result is only meaningful on the intended capture cycle, inverted otherwise.
    always_comb begin
        logic [FLAT_W:0] res;
        logic            ok;
        res = alu_ref(bus.alu_opcode, bus.alu_A_flat, bus.alu_B_flat, bus.alu_f);
        if (bus.alu_opcode == OP_MUL) ok = !mul_stall && (op_age == mul_k - 1);
        else                          ok = (bus.alu_opcode != OP_NOP) && (op_age == 1);
        bus.alu_C_flat   = ok ? res[FLAT_W-1:0] : ~res[FLAT_W-1:0];
        bus.alu_overflow = ok ? res[FLAT_W] : ~res[FLAT_W];
        bus.alu_done     = ok;
    end

    task automatic chk(input string tag, input logic [FLAT_W-1:0] got, input logic [FLAT_W-1:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic fill_rand(input logic [7:0] base);
        for (int i = 0; i < 5; i++) mem[base + 8'(i)] = 40'({$urandom, $urandom});
    endtask

    task automatic fill_const(input logic [7:0] base, input logic [7:0] e);
        for (int i = 0; i < 5; i++) mem[base + 8'(i)] = {5{e}};
    endtask

    function automatic logic [FLAT_W-1:0] read_mat(input logic [7:0] base);
        logic [FLAT_W-1:0] m;
        for (int i = 0; i < 5; i++) m[40*i +: 40] = mem[base + 8'(i)];
        return m;
    endfunction

    // Issue one command (called #1 after an edge with the DUT idle) and check its outcome.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c, input logic [7:0] sc,
                           input int glitch);
        logic [FLAT_W:0]   r;
        logic [FLAT_W-1:0] mb;
        logic [7:0]        addr0;
        logic              legal, bin;
        int                exp_cyc, cyc;
        legal = (op != 3'b000) && (op != 3'b111);
        bin   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
        mb    = bin ? read_mat(b) : '0;
        r     = alu_ref(op, read_mat(a), mb, sc);
        for (int i = 0; i < 5; i++) mem[c + 8'(i)] = ~r[40*i +: 40];
        if (!legal)                       exp_cyc = 1;
        else if (op == OP_MUL && mul_stall) exp_cyc = 12 + int'(MUL_TO) + 1;
        else if (op == OP_MUL)            exp_cyc = 12 + mul_k + 6;
        else if (bin)                     exp_cyc = 20;
        else                              exp_cyc = 14;
        wr_cnt  = 0;
        b_reads = 0;
        b_base  = b;
        b_mon   = !bin;
        addr0   = bus.mem_addr;
        bus.start = 1'b1; bus.cmd_opcode = op; bus.cmd_scalar = sc;
        bus.cmd_addr_a = a; bus.cmd_addr_b = b; bus.cmd_addr_c = c;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 400) begin
            @(posedge clock); #1;
            cyc = cyc + 1;
            if (cyc == glitch) begin
                bus.start = 1'b1; bus.cmd_opcode = 3'b111; bus.cmd_addr_a = b;
            end else begin
                bus.start = 1'b0;
            end
        end
        b_mon = 1'b0;
        chk({tag, "_done_cyc"}, FLAT_W'(cyc), FLAT_W'(exp_cyc));
        chk({tag, "_busy"}, FLAT_W'(bus.busy), '0);
        if (!legal) begin
            chk({tag, "_err"}, FLAT_W'(bus.error), FLAT_W'(1));
            chk({tag, "_writes"}, FLAT_W'(wr_cnt), '0);
            chk({tag, "_addr"}, FLAT_W'(bus.mem_addr), FLAT_W'(addr0));
        end else if (op == OP_MUL && mul_stall) begin
            chk({tag, "_err"}, FLAT_W'(bus.error), FLAT_W'(1));
            chk({tag, "_writes"}, FLAT_W'(wr_cnt), '0);
        end else begin
            chk({tag, "_err"}, FLAT_W'(bus.error), '0);
            chk({tag, "_ovf"}, FLAT_W'(bus.overflow), FLAT_W'(r[FLAT_W]));
            chk({tag, "_writes"}, FLAT_W'(wr_cnt), FLAT_W'(5));
            chk({tag, "_C"}, read_mat(c), r[FLAT_W-1:0]);
            if (!bin) chk({tag, "_b_reads"}, FLAT_W'(b_reads), '0);
        end
        chk({tag, "_opcode_idle"}, FLAT_W'(bus.alu_opcode), '0);
    endtask

    initial begin
        int cyc_r;
        n_chk = 0; n_pass = 0;
        wr_cnt = 0; b_reads = 0; b_mon = 1'b0; b_base = '0;
        mul_k = 7; mul_stall = 1'b0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.cmd_opcode = '0; bus.cmd_scalar = '0;
        bus.cmd_addr_a = '0; bus.cmd_addr_b = '0; bus.cmd_addr_c = '0;
        for (int i = 0; i < 256; i++) mem[i] = 40'({$urandom, $urandom});
        repeat (2) @(posedge clock); #1;
        chk("rst_we", FLAT_W'(bus.mem_we), '0);
        chk("rst_addr", FLAT_W'(bus.mem_addr), '0);
        chk("rst_wdata", FLAT_W'(bus.mem_wdata), '0);
        chk("rst_opcode", FLAT_W'(bus.alu_opcode), '0);
        chk("rst_A", bus.alu_A_flat, '0);
        chk("rst_B", bus.alu_B_flat, '0);
        chk("rst_busy", FLAT_W'(bus.busy), '0);
        chk("rst_done", FLAT_W'(bus.done), '0);
        chk("rst_flags", FLAT_W'({bus.overflow, bus.error}), '0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Sum with A wrapping past address 255.
        fill_const(8'hFE, 8'h01);
        fill_const(8'h03, 8'h02);
        run_cmd("sum", OP_ADD, 8'hFE, 8'h03, 8'h08, 8'h00, -1);
        chk("sum_row0", FLAT_W'(mem[8'h08]), FLAT_W'(40'h0303030303));
        chk("sum_row4", FLAT_W'(mem[8'h0C]), FLAT_W'(40'h0303030303));

        fill_const(8'h20, 8'h40);
        fill_rand(8'h25);
        run_cmd("scl", OP_SCL, 8'h20, 8'h25, 8'h2A, 8'd3, -1);
        chk("scl_ovf_set", FLAT_W'(bus.overflow), FLAT_W'(1));
        chk("scl_row2", FLAT_W'(mem[8'h2C]), FLAT_W'(40'hC0C0C0C0C0));

        fill_rand(8'h40);
        fill_rand(8'h45);
        run_cmd("mul", OP_MUL, 8'h40, 8'h45, 8'h4A, 8'h00, -1);

        mul_stall = 1'b1;
        run_cmd("mul_to", OP_MUL, 8'h40, 8'h45, 8'h50, 8'h00, -1);
        mul_stall = 1'b0;

        run_cmd("illegal", 3'b111, 8'h60, 8'h65, 8'h6A, 8'h00, -1);
        fill_rand(8'h60);
        fill_rand(8'h65);
        run_cmd("ignore_start", OP_SUB, 8'h60, 8'h65, 8'h6A, 8'h00, 3);

        // Reset while row 2 of C is being written.
        fill_rand(8'h80);
        fill_rand(8'h85);
        for (int i = 0; i < 5; i++) mem[8'h8A + 8'(i)] = '0;
        wr_cnt = 0;
        bus.start = 1'b1; bus.cmd_opcode = OP_ADD;
        bus.cmd_addr_a = 8'h80; bus.cmd_addr_b = 8'h85; bus.cmd_addr_c = 8'h8A;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cyc_r = 0;
        while (!(bus.mem_we && bus.mem_addr == 8'h8C) && cyc_r < 60) begin
            @(posedge clock); #1;
            cyc_r = cyc_r + 1;
        end
        chk("rs_reach_row2", FLAT_W'(cyc_r), FLAT_W'(16));
        #3 reset_n = 1'b0;
        #1;
        chk("rs_we", FLAT_W'(bus.mem_we), '0);
        chk("rs_busy", FLAT_W'(bus.busy), '0);
        chk("rs_addr", FLAT_W'(bus.mem_addr), '0);
        chk("rs_opcode", FLAT_W'(bus.alu_opcode), '0);
        chk("rs_A", bus.alu_A_flat, '0);
        repeat (3) @(posedge clock); #1;
        chk("rs_writes", FLAT_W'(wr_cnt), FLAT_W'(2));
        chk("rs_row2", FLAT_W'(mem[8'h8C]), '0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_cmd("post_rst", OP_ADD, 8'h80, 8'h85, 8'h8A, 8'h00, -1);

        for (int n = 0; n < 12; n++) begin
            logic [7:0] a;
            logic [2:0] op;
            a  = 8'($urandom);
            op = 3'($urandom_range(1, 6));
            mul_k = $urandom_range(2, 20);
            fill_rand(a);
            fill_rand(a + 8'd5);
            run_cmd($sformatf("rnd%0d_op%0d", n, op), op, a, a + 8'd5, a + 8'd10,
                    8'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
